// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types for the rt-ibex preemptive context-save stack.
// The default-sized frame and count types match the stack's default parameters.
package rt_ibex_pcs_pkg;

    localparam int unsigned NrSavedRegsDef   = 9;
    localparam int unsigned DataWidthDef     = 32;
    localparam int unsigned IrqLevelWidthDef = 8;
    localparam int unsigned DepthDef         = 8;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        STORE          = 2'd1,
        RESTORE        = 2'd2,
        RETURN_RESTORE = 2'd3
    } state_t;

    typedef struct packed {
        logic [IrqLevelWidthDef-1:0]                 level;
        logic [NrSavedRegsDef-1:0][DataWidthDef-1:0] regs;
    } frame_t;

    typedef logic [$clog2(DepthDef+1)-1:0] pcs_cnt_t;

endpackage

// File: rtl/rt_ibex_pcs_stack_mem.sv
// Frame storage for the context-save stack: one write port and one registered read port.
// The array itself is never reset; only the read register is.
module rt_ibex_pcs_stack_mem
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned Depth      = DepthDef,
    parameter int unsigned FrameWidth = 8,
    parameter int unsigned AddrWidth  = $clog2(Depth)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we,
    input  logic [AddrWidth-1:0]  waddr,
    input  logic [FrameWidth-1:0] wdata,
    input  logic                  re,
    input  logic [AddrWidth-1:0]  raddr,
    output logic [FrameWidth-1:0] rdata
);

    logic [FrameWidth-1:0] mem_r [Depth];
    logic [FrameWidth-1:0] rdata_r;

    // frame array write port
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // read register: keeps the last popped frame until the next pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rt_ibex_pcs_stack.sv
// Context-save stack for nested interrupts: pushes register frames on ack,
// pops the top frame ahead of mret and strobes it out for register-file restore.
module rt_ibex_pcs_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned NrSavedRegs   = NrSavedRegsDef,
    parameter int unsigned DataWidth     = DataWidthDef,
    parameter int unsigned IrqLevelWidth = IrqLevelWidthDef,
    parameter int unsigned Depth         = DepthDef
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [IrqLevelWidth-1:0]                irq_level_i,
    input  logic                                    irq_ack_i,
    input  logic                                    next_mret_i,
    input  logic                                    clear_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]   store_data_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]   restore_data_o,
    output logic [IrqLevelWidth-1:0]                restore_level_o,
    output logic                                    restore_en_o,
    output logic [$clog2(Depth+1)-1:0]              count_o,
    output logic                                    full_o,
    output logic                                    empty_o,
    output logic                                    overflow_o,
    output logic                                    underflow_o
);

    localparam int unsigned CntW   = $clog2(Depth+1);
    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned RegsW  = NrSavedRegs * DataWidth;
    localparam int unsigned FrameW = IrqLevelWidth + RegsW;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    state_t            state_r, next_state_s;
    logic [CntW-1:0]   count_r;
    logic              ack_pend_r, overflow_r, underflow_r, restore_en_r;
    logic              ack_req_s, full_s, empty_s;
    logic              mem_we_s, mem_re_s, cnt_inc_s, cnt_dec_s;
    logic              set_over_s, set_under_s, pend_set_s, pend_clr_s;
    logic [FrameW-1:0] rdata_s;

    assign ack_req_s = irq_ack_i | ack_pend_r;
    assign full_s    = (count_r == CntFull);
    assign empty_s   = (count_r == '0);

    // next-state and datapath controls
    always_comb begin
        next_state_s = state_r;
        mem_we_s     = 1'b0;
        mem_re_s     = 1'b0;
        cnt_inc_s    = 1'b0;
        cnt_dec_s    = 1'b0;
        set_over_s   = 1'b0;
        set_under_s  = 1'b0;
        pend_set_s   = 1'b0;
        pend_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ack_req_s) begin
                    next_state_s = STORE;
                    pend_clr_s   = 1'b1;
                    // a fresh ack on top of a pending one cannot be queued
                    set_over_s   = irq_ack_i & ack_pend_r;
                end else if (next_mret_i) begin
                    if (empty_s) begin
                        set_under_s = 1'b1;
                    end else begin
                        next_state_s = RESTORE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            STORE: begin
                next_state_s = IDLE;
                if (full_s) begin
                    set_over_s = 1'b1;
                end else begin
                    mem_we_s  = 1'b1;
                    cnt_inc_s = 1'b1;
                end
            end
            RESTORE: begin
                next_state_s = RETURN_RESTORE;
                mem_re_s     = 1'b1;
            end
            RETURN_RESTORE: begin
                next_state_s = IDLE;
                cnt_dec_s    = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if ((state_r != IDLE) && irq_ack_i) begin
            if (ack_pend_r) begin
                set_over_s = 1'b1;
            end else begin
                pend_set_s = 1'b1;
            end
        end else begin
            pend_set_s = pend_set_s;
        end
    end

    // FSM, occupancy, pending ack, sticky flags and strobe; clear_i overrides all
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            count_r      <= '0;
            ack_pend_r   <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            restore_en_r <= 1'b0;
        end else if (clear_i) begin
            state_r      <= IDLE;
            count_r      <= '0;
            ack_pend_r   <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            restore_en_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            restore_en_r <= (next_state_s == RETURN_RESTORE);
            overflow_r   <= overflow_r | set_over_s;
            underflow_r  <= underflow_r | set_under_s;
            if (cnt_inc_s) begin
                count_r <= count_r + CntOne;
            end else if (cnt_dec_s) begin
                count_r <= count_r - CntOne;
            end
            if (pend_set_s) begin
                ack_pend_r <= 1'b1;
            end else if (pend_clr_s) begin
                ack_pend_r <= 1'b0;
            end
        end
    end

    rt_ibex_pcs_stack_mem #(
        .Depth      (Depth),
        .FrameWidth (FrameW),
        .AddrWidth  (AddrW)
    ) u_mem (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (mem_we_s & ~clear_i),
        .waddr  (AddrW'(count_r)),
        .wdata  ({irq_level_i, store_data_i}),
        .re     (mem_re_s & ~clear_i),
        .raddr  (AddrW'(count_r - CntOne)),
        .rdata  (rdata_s)
    );

    // a flush in the strobe cycle suppresses the restore
    assign restore_en_o    = restore_en_r & ~clear_i;
    assign restore_data_o  = rdata_s[RegsW-1:0];
    assign restore_level_o = rdata_s[FrameW-1 -: IrqLevelWidth];
    assign count_o         = count_r;
    assign full_o          = full_s;
    assign empty_o         = empty_s;
    assign overflow_o      = overflow_r;
    assign underflow_o     = underflow_r;

endmodule
